// File: rtl/result_wr_pkg.sv
// result_wr_pkg
//   Shared constants and types for the result write master: default burst
//   geometry, FSM state encoding, AXI size/burst/response codes, the 64-byte
//   beat width and the tail-beat byte-strobe helper.
package result_wr_pkg;

  localparam int unsigned BURST_BEATS_DEF = 64;   // beats per AXI write burst
  localparam int unsigned MAX_OUTST_DEF   = 4;    // AW bursts allowed without B
  localparam int unsigned BEAT_BYTES      = 64;   // bytes per 512-bit beat

  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } wr_state_e;

  // Byte strobe for the final beat of a page: bytes below len_lo are valid,
  // a zero remainder means the final beat is completely full.
  function automatic logic [63:0] tail_strb(input logic [5:0] len_lo);
    logic [63:0] mask;
    if (len_lo == 6'd0) begin
      mask = {64{1'b1}};
    end else begin
      mask = (64'd1 << len_lo) - 64'd1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/result_wr_beat_cnt.sv
// result_wr_beat_cnt
//   Tracks beats covered by issued AW bursts, W beats sent, and the beat index
//   inside the current W burst. Produces w_credit (an AW covers the next W
//   beat), wlast (last beat of the current burst) and page_last (final beat
//   of the page).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             clears all counters at the start of a page
//   total_beats     beats in the current page
//   aw_fire/aw_len  AW handshake and its awlen
//   w_fire          W handshake
//   w_credit, wlast, page_last  status outputs
module result_wr_beat_cnt #(
  parameter int unsigned BURST_BEATS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [31:0] total_beats,
  input  logic        aw_fire,
  input  logic [7:0]  aw_len,
  input  logic        w_fire,
  output logic        w_credit,
  output logic        wlast,
  output logic        page_last
);

  localparam logic [7:0] IDX_LAST = 8'(BURST_BEATS - 1);

  logic [31:0] aw_beats_r;
  logic [31:0] w_beats_r;
  logic [7:0]  beat_idx_r;

  assign w_credit  = (aw_beats_r > w_beats_r);
  assign page_last = (w_beats_r == (total_beats - 32'd1));
  // Every burst but the last is full, so the burst boundary is either a full
  // burst index or the page's final beat.
  assign wlast     = page_last | (beat_idx_r == IDX_LAST);

  // Beat accounting for AW coverage, W progress and in-burst index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_beats_r <= 32'd0;
      w_beats_r  <= 32'd0;
      beat_idx_r <= 8'd0;
    end else if (clr) begin
      aw_beats_r <= 32'd0;
      w_beats_r  <= 32'd0;
      beat_idx_r <= 8'd0;
    end else begin
      if (aw_fire) begin
        aw_beats_r <= aw_beats_r + {24'd0, aw_len} + 32'd1;
      end
      if (w_fire) begin
        w_beats_r  <= w_beats_r + 32'd1;
        beat_idx_r <= wlast ? 8'd0 : (beat_idx_r + 8'd1);
      end
    end
  end

endmodule

// File: rtl/result_wr_master.sv
// result_wr_master
//   Writes one decompressed page from a 512-bit result stream to memory as a
//   sequence of AXI INCR write bursts, limiting outstanding bursts and
//   reporting completion (done) and any write error (error).
//   Optional build macro RESULT_WR_LAST_CHECK_EN: flags an error when the
//   stream's in_last disagrees with the internally generated wlast.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   start, dest_addr, decompression_length   page command (sampled in IDLE)
//   in_data/in_valid/in_last/in_ready   result stream input
//   m_axi_aw*, m_axi_w*, m_axi_b*       AXI write master channels
//   done                                one-cycle pulse, page acknowledged
//   error                               sticky until the next start
module result_wr_master
  import result_wr_pkg::*;
#(
  parameter int unsigned BURST_BEATS = BURST_BEATS_DEF,
  parameter int unsigned MAX_OUTST   = MAX_OUTST_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  dest_addr,
  input  logic [31:0]  decompression_length,
  input  logic [511:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [63:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic [1:0]   m_axi_awburst,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [511:0] m_axi_wdata,
  output logic [63:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic         done,
  output logic         error
);

  localparam logic [63:0] BURST_BYTES = 64'(BURST_BEATS * BEAT_BYTES);
  localparam logic [7:0]  LEN_FULL    = 8'(BURST_BEATS - 1);
  localparam logic [31:0] BB32        = 32'(BURST_BEATS);
  localparam logic [31:0] OUTST32     = 32'(MAX_OUTST);

  wr_state_e   state_r, state_next_s;
  logic        done_r, done_next_s;
  logic        error_r;
  logic [31:0] total_beats_r, bursts_r;
  logic [5:0]  len_lo_r;
  logic [31:0] b_cnt_r, outst_r;
  logic        awvalid_r;
  logic [63:0] awaddr_r, next_addr_r;
  logic [7:0]  awlen_r;
  logic [31:0] aw_rem_r;

  logic        start_go_s, run_s, active_s;
  logic        aw_fire_s, w_fire_s, b_fire_s;
  logic        w_credit_s, wlast_s, page_last_s, last_mis_s, unused_s;
  logic [31:0] total_beats_s, bursts_s;

  assign start_go_s = (state_r == ST_IDLE) & start;
  assign run_s      = (state_r == ST_RUN);
  assign active_s   = (state_r == ST_RUN) | (state_r == ST_DRAIN);

  // ceil(len/64) without overflow, then ceil(beats/BURST_BEATS).
  assign total_beats_s = {6'd0, decompression_length[31:6]} +
                         {31'd0, |decompression_length[5:0]};
  assign bursts_s      = (total_beats_s / BB32) +
                         {31'd0, ((total_beats_s % BB32) != 32'd0)};

  assign aw_fire_s = awvalid_r & m_axi_awready;
  assign w_fire_s  = m_axi_wvalid & m_axi_wready;
  assign b_fire_s  = m_axi_bvalid & active_s;

  result_wr_beat_cnt #(
    .BURST_BEATS(BURST_BEATS)
  ) u_beat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_go_s),
    .total_beats(total_beats_r),
    .aw_fire    (aw_fire_s),
    .aw_len     (awlen_r),
    .w_fire     (w_fire_s),
    .w_credit   (w_credit_s),
    .wlast      (wlast_s),
    .page_last  (page_last_s)
  );

`ifdef RESULT_WR_LAST_CHECK_EN
  assign last_mis_s = w_fire_s & (in_last != wlast_s);
  assign unused_s   = ^dest_addr[11:0];
`else
  assign last_mis_s = 1'b0;
  assign unused_s   = ^{dest_addr[11:0], in_last};
`endif

  // Next-state and done-pulse decode.
  always_comb begin
    state_next_s = state_r;
    done_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (decompression_length == 32'd0) begin
            done_next_s  = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_fire_s & page_last_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Counting the B accepted this cycle lets done follow the final B
        // by exactly one cycle.
        if ((b_cnt_r + {31'd0, b_fire_s}) == bursts_r) begin
          state_next_s = ST_IDLE;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= done_next_s;
    end
  end

  // Page context captured when a page is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_beats_r <= 32'd0;
      bursts_r      <= 32'd0;
      len_lo_r      <= 6'd0;
    end else if (start_go_s) begin
      total_beats_r <= total_beats_s;
      bursts_r      <= bursts_s;
      len_lo_r      <= decompression_length[5:0];
    end
  end

  // AW channel: one burst at a time, held until awready, throttled by the
  // outstanding-burst limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_r   <= 1'b0;
      awaddr_r    <= 64'd0;
      awlen_r     <= 8'd0;
      next_addr_r <= 64'd0;
      aw_rem_r    <= 32'd0;
    end else if (start_go_s) begin
      awvalid_r   <= 1'b0;
      next_addr_r <= {dest_addr[63:12], 12'h000};
      aw_rem_r    <= total_beats_s;
    end else if (run_s) begin
      if (awvalid_r) begin
        if (m_axi_awready) begin
          awvalid_r   <= 1'b0;
          next_addr_r <= next_addr_r + BURST_BYTES;
          aw_rem_r    <= aw_rem_r - ({24'd0, awlen_r} + 32'd1);
        end else begin
          awvalid_r <= 1'b1;
        end
      end else if ((aw_rem_r != 32'd0) && (outst_r < OUTST32)) begin
        awvalid_r <= 1'b1;
        awaddr_r  <= next_addr_r;
        awlen_r   <= (aw_rem_r >= BB32) ? LEN_FULL : (aw_rem_r[7:0] - 8'd1);
      end else begin
        awvalid_r <= 1'b0;
      end
    end else begin
      awvalid_r <= 1'b0;
    end
  end

  // B response count and outstanding-burst tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt_r <= 32'd0;
      outst_r <= 32'd0;
    end else if (start_go_s) begin
      b_cnt_r <= 32'd0;
      outst_r <= 32'd0;
    end else if (active_s) begin
      b_cnt_r <= b_cnt_r + {31'd0, b_fire_s};
      case ({aw_fire_s, b_fire_s})
        2'b10:   outst_r <= outst_r + 32'd1;
        2'b01:   outst_r <= outst_r - 32'd1;
        default: outst_r <= outst_r;
      endcase
    end
  end

  // Sticky error: cleared by an accepted start, set by a bad response or a
  // stream framing mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r <= 1'b0;
    end else if (start_go_s) begin
      error_r <= 1'b0;
    end else if ((b_fire_s & (m_axi_bresp != AXI_RESP_OKAY)) | last_mis_s) begin
      error_r <= 1'b1;
    end
  end

  assign m_axi_awaddr  = awaddr_r;
  assign m_axi_awlen   = awlen_r;
  assign m_axi_awsize  = AXI_SIZE_64B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = awvalid_r;

  // W passes straight through from the stream; credit keeps W behind AW.
  assign m_axi_wvalid  = run_s & in_valid & w_credit_s;
  assign in_ready      = run_s & m_axi_wready & w_credit_s;
  assign m_axi_wdata   = in_data;
  assign m_axi_wlast   = wlast_s;
  assign m_axi_wstrb   = page_last_s ? tail_strb(len_lo_r) : {64{1'b1}};

  assign m_axi_bready  = 1'b1;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_result_wr_master.sv
// tb_result_wr_master
//   Directed bench for result_wr_master with a page-level reference model:
//   on each accepted start it lists the AW bursts and W beats the page must
//   produce, and a negedge process compares every handshake, the credit
//   gating, done and error against it. Literal expectations pin key values.
module tb_result_wr_master;

  localparam int BB = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [63:0]  dest_addr;
  logic [31:0]  decompression_length;
  logic [511:0] in_data;
  logic         in_valid, in_last, in_ready;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid, m_axi_awready;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic         done, error;

  result_wr_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dest_addr(dest_addr),
    .decompression_length(decompression_length),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [511:0] data; logic [63:0] strb; logic last; } w_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  logic [63:0] aw_log_addr[$];
  logic [7:0]  aw_log_len[$];
  logic [63:0] last_strb_log;

  int n_checks = 0, n_errors = 0;
  int busy = 0, cur_total = 0, cur_bursts = 0;
  int w_seen = 0, aw_cov = 0, wlast_cnt = 0, b_sent = 0, done_cnt = 0;
  bit done_pend = 1'b0, err_model = 1'b0;
  logic [31:0] seed = 32'h5EED_0001;
  int b_allow = 1000000, bad_burst = -1, corrupt_idx = -1;
  bit wr_gap = 1'b0, in_gap = 1'b0;
  int cyc = 0;

  function automatic logic [511:0] data_of(input int i);
    logic [511:0] d;
    logic [31:0] w;
    w = 32'(i) ^ seed;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = w + 32'(k);
    return d;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Page model: AW list and beat list from length/address arithmetic.
  task automatic build_page(input logic [63:0] addr, input logic [31:0] len);
    longint total, bursts, rem;
    logic [63:0] base;
    aw_t a;
    w_t w;
    int vb;
    total  = (longint'(len) + 63) / 64;
    bursts = (total + BB - 1) / BB;
    base   = addr & ~64'hFFF;
    for (longint k = 0; k < bursts; k++) begin
      rem    = total - k * BB;
      a.addr = base + 64'(k * BB * 64);
      a.len  = 8'(((rem > BB) ? BB : rem) - 1);
      exp_aw.push_back(a);
    end
    for (longint i = 0; i < total; i++) begin
      w.data = data_of(int'(i));
      w.strb = {64{1'b1}};
      if (i == total - 1) begin
        vb = int'(longint'(len) - 64 * (total - 1));
        for (int b = 0; b < 64; b++) w.strb[b] = (b < vb);
      end
      w.last = ((i % BB) == BB - 1) || (i == total - 1);
      exp_w.push_back(w);
    end
    cur_total = int'(total);
    cur_bursts = int'(bursts);
    w_seen = 0; aw_cov = 0; wlast_cnt = 0; b_sent = 0;
  endtask

  // Compare process: outputs reflect events up to the last edge; the model
  // is then advanced with the handshakes the coming edge will take.
  always @(negedge clk) begin
    aw_t a;
    w_t  w;
    bit  done_now;
    cyc++;
    if (rst_n) begin
      done_now = 1'b0;
      chk("bready", m_axi_bready, 1'b1);
      chk("done", done, done_pend);
      chk("error", error, err_model);
      chk("in_ready", in_ready, m_axi_wready && (w_seen < aw_cov));
      chk("wvalid", m_axi_wvalid, in_valid && (w_seen < aw_cov));
      if (m_axi_wvalid && m_axi_wready && exp_w.size() > 0) begin
        chk("w_before_aw", (w_seen < aw_cov), 1'b1);
        w = exp_w.pop_front();
        chk("wdata", m_axi_wdata, w.data);
        chk("wstrb", m_axi_wstrb, w.strb);
        chk("wlast", m_axi_wlast, w.last);
        if (w.last) wlast_cnt++;
        if (w_seen == cur_total - 1) last_strb_log = m_axi_wstrb;
`ifdef RESULT_WR_LAST_CHECK_EN
        if (in_last != w.last) err_model = 1'b1;
`endif
        w_seen++;
      end
      if (exp_aw.size() == 0) begin
        chk("awvalid_unexpected", m_axi_awvalid, 1'b0);
      end else if (m_axi_awvalid && m_axi_awready) begin
        a = exp_aw.pop_front();
        chk("awaddr", m_axi_awaddr, a.addr);
        chk("awlen", m_axi_awlen, a.len);
        chk("awsize", m_axi_awsize, 3'b110);
        chk("awburst", m_axi_awburst, 2'b01);
        aw_cov += int'(a.len) + 1;
        aw_log_addr.push_back(m_axi_awaddr);
        aw_log_len.push_back(m_axi_awlen);
      end
      if (m_axi_bvalid) begin
        b_sent++;
        if (busy != 0) begin
          if (m_axi_bresp != 2'b00) err_model = 1'b1;
          if (b_sent == cur_bursts) begin
            done_now = 1'b1;
            busy = 0;
          end
        end
      end
      if (start && busy == 0) begin
        err_model = 1'b0;
        if (decompression_length == 32'd0) begin
          done_now = 1'b1;
        end else begin
          build_page(dest_addr, decompression_length);
          busy = 1;
        end
      end
      if (done) done_cnt++;
      done_pend = done_now;
    end
  end

  task automatic drive();
    start    = 1'b0;
    in_valid = (busy != 0) && (w_seen < cur_total) && !(in_gap && (cyc % 4 == 1));
    in_data  = data_of(w_seen);
    in_last  = ((w_seen % BB) == BB - 1) || (w_seen == cur_total - 1);
    if (w_seen == corrupt_idx) in_last = ~in_last;
    m_axi_wready = !(wr_gap && (cyc % 3 == 0));
    m_axi_bvalid = (wlast_cnt > b_sent) && (b_sent < b_allow);
    m_axi_bresp  = (b_sent == bad_burst) ? 2'b10 : 2'b00;
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic start_page(input logic [63:0] a, input logic [31:0] l);
    dest_addr = a;
    decompression_length = l;
    start = 1'b1;
    cyc1();
  endtask

  task automatic wait_done(input int tgt, input int limit);
    int n;
    n = 0;
    while (done_cnt < tgt && n < limit) begin
      cyc1();
      n++;
    end
    chk("done_timeout", (done_cnt >= tgt), 1'b1);
    cyc1();
  endtask

  task automatic clear_log();
    aw_log_addr.delete();
    aw_log_len.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    rst_n = 1'b0; start = 1'b0; dest_addr = 64'd0; decompression_length = 32'd0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    #2;
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    repeat (3) cyc1();
    rst_n = 1'b1;
    cyc1();

    // Two full bursts; a second start mid-page must be ignored.
    clear_log(); d0 = done_cnt; seed = 32'h1111_0000;
    start_page(64'h1000, 32'd8192);
    repeat (20) cyc1();
    start_page(64'hDEAD_0000, 32'd64);
    wait_done(d0 + 1, 1000);
    chk("t2_aw_count", aw_log_addr.size(), 2);
    chk("t2_aw0_addr", aw_log_addr[0], 64'h1000);
    chk("t2_aw1_addr", aw_log_addr[1], 64'h2000);
    chk("t2_aw1_len", aw_log_len[1], 8'd63);
    chk("t2_w_beats", w_seen, 128);
    chk("t2_wlast_count", wlast_cnt, 2);
    chk("t2_done_count", done_cnt, d0 + 1);

    // 100 bytes: one 2-beat burst, 36 valid bytes on the last beat.
    clear_log(); d0 = done_cnt; seed = 32'h2222_0000; wr_gap = 1'b1; in_gap = 1'b1;
    start_page(64'h5ABC, 32'd100);
    wait_done(d0 + 1, 200);
    chk("t3_aw_count", aw_log_addr.size(), 1);
    chk("t3_aw_addr", aw_log_addr[0], 64'h5000);
    chk("t3_aw_len", aw_log_len[0], 8'd1);
    chk("t3_tail_strb", last_strb_log, 64'h0000_000F_FFFF_FFFF);
    chk("t3_w_beats", w_seen, 2);
    wr_gap = 1'b0; in_gap = 1'b0;

    // Zero length: immediate done, no AXI traffic.
    clear_log(); d0 = done_cnt;
    start_page(64'h7000, 32'd0);
    repeat (3) cyc1();
    chk("t4_done_count", done_cnt, d0 + 1);
    chk("t4_aw_count", aw_log_addr.size(), 0);

    // Outstanding limit: 8 bursts with B withheld.
    clear_log(); d0 = done_cnt; seed = 32'h3333_0000; b_allow = 0;
    start_page(64'h10000, 32'd32768);
    repeat (400) cyc1();
    chk("t5_aw_stalled", aw_log_addr.size(), 4);
    chk("t5_w_beats", w_seen, 256);
    b_allow = 1;
    repeat (20) cyc1();
    chk("t5_aw_after_b", aw_log_addr.size(), 5);
    b_allow = 1000000;
    wait_done(d0 + 1, 2000);
    chk("t5_aw_total", aw_log_addr.size(), 8);

    // AW stalled at page start: no stream acceptance.
    d0 = done_cnt; seed = 32'h4444_0000; m_axi_awready = 1'b0;
    start_page(64'h20000, 32'd8192);
    for (int i = 0; i < 10; i++) begin
      cyc1();
      chk("t6_in_ready_stall", in_ready, 1'b0);
      chk("t6_wvalid_stall", m_axi_wvalid, 1'b0);
    end
    m_axi_awready = 1'b1;
    wait_done(d0 + 1, 1000);

    // Error response on the first of two bursts; next start clears it.
    d0 = done_cnt; seed = 32'h5555_0000; bad_burst = 0;
    start_page(64'h30000, 32'd8192);
    wait_done(d0 + 1, 1000);
    chk("t7_error_set", error, 1'b1);
    repeat (3) cyc1();
    chk("t7_error_sticky", error, 1'b1);
    bad_burst = -1;
    start_page(64'h40000, 32'd64);
    cyc1();
    chk("t7_error_cleared", error, 1'b0);
    wait_done(d0 + 2, 200);

    // Reset while beat 30 is on offer.
    seed = 32'h6666_0000;
    start_page(64'h50000, 32'd8192);
    n = 0;
    while (w_seen < 30 && n < 300) begin
      cyc1();
      n++;
    end
    chk("t8_reach_beat30", (w_seen >= 30), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_rst_awvalid", m_axi_awvalid, 1'b0);
    chk("t8_rst_wvalid", m_axi_wvalid, 1'b0);
    chk("t8_rst_in_ready", in_ready, 1'b0);
    chk("t8_rst_done", done, 1'b0);
    chk("t8_rst_error", error, 1'b0);
    exp_aw.delete(); exp_w.delete();
    busy = 0; done_pend = 1'b0; err_model = 1'b0;
    w_seen = 0; aw_cov = 0; wlast_cnt = 0; b_sent = 0; cur_total = 0;
    repeat (2) cyc1();
    rst_n = 1'b1;
    repeat (5) cyc1();
    d0 = done_cnt; seed = 32'h7777_0000;
    start_page(64'h60000, 32'd128);
    wait_done(d0 + 1, 200);

`ifdef RESULT_WR_LAST_CHECK_EN
    // Stream framing disagreement on beat 10.
    d0 = done_cnt; seed = 32'h8888_0000; corrupt_idx = 10;
    start_page(64'h70000, 32'd4096);
    wait_done(d0 + 1, 400);
    chk("t9_last_mismatch_error", error, 1'b1);
    corrupt_idx = -1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
